// File: rtl/fetch_seq_ctrl_if.sv
// fetch_seq_ctrl_if
// -----------------
// Bundles the fetch sequencer's handshake with the outside world:
// the redirect/stall inputs from the pipeline, the SRAM fetch port,
// and the instruction presented to decode.
//
// Signals:
//   redirect_valid / redirect_pc : jump, branch or trap redirect request
//   dec_stall                    : decoder cannot take the current instruction
//   sram_ready                   : fetch port granted this cycle
//   sram_cs / sram_addr          : fetch request strobe and 64-bit line address
//   sram_rdata                   : line data, one cycle after a granted request
//   instr_valid / instr_pc       : instruction presentation qualifier and its PC
//   instr / instr_is16           : raw instruction (RV16 zero-extended) and size flag
//
// Modports:
//   master : the fetch sequencer (drives the SRAM request and the instruction)
//   slave  : the surrounding pipeline plus SRAM
interface fetch_seq_ctrl_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_stall;
    logic        sram_ready;
    logic        sram_cs;
    logic [28:0] sram_addr;
    logic [63:0] sram_rdata;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic [31:0] instr;
    logic        instr_is16;

    modport master (
        input  redirect_valid, redirect_pc, dec_stall, sram_ready, sram_rdata,
        output sram_cs, sram_addr, instr_valid, instr_pc, instr, instr_is16
    );

    modport slave (
        output redirect_valid, redirect_pc, dec_stall, sram_ready, sram_rdata,
        input  sram_cs, sram_addr, instr_valid, instr_pc, instr, instr_is16
    );
endinterface

// File: rtl/fetch_seq_ctrl.sv
// fetch_seq_ctrl
// --------------
// Instruction fetch sequencer. Requests 64-bit lines from the fetch SRAM
// at the current fetch PC, holds the returned line, and extracts one
// RV32 or RV16 instruction per decoder accept. A 32-bit instruction whose
// lower half sits in the last halfword of a line is assembled from that
// saved halfword plus the first halfword of the following line.
//
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : asynchronous active-high reset
//   bus : fetch_seq_ctrl_if.master (redirect, stall, SRAM port, instruction out)
//
// Parameters:
//   RESET_PC : first fetch address after reset (bit 0 ignored)
module fetch_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    fetch_seq_ctrl_if.master        bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RUN
    } state_t;

    state_t      state_q;
    logic [31:1] pc_q;
    logic [63:0] line_q;
    logic [31:3] tag_q;
    logic [15:0] hw_q;
    logic        xmode_q;

    logic [28:0] req_addr;
    logic [15:0] lo_hw;
    logic [15:0] hi_hw;
    logic [31:0] instr_sel;
    logic        is16;
    logic        straddle;
    logic        valid;
    logic        accept;
    logic [31:0] pc_d;
    logic        unused_bits;

    // Instruction extraction from the held line. lo_hw is the halfword at
    // the PC, hi_hw the one after it (meaningless for the last halfword,
    // which is why that slot is either RV16 or a straddle). In xmode the
    // lower half was saved from the previous line and the upper half is
    // the first halfword of the freshly fetched one.
    always_comb begin
        lo_hw = 16'h0000;
        hi_hw = 16'h0000;
        case (pc_q[2:1])
            2'b00: begin lo_hw = line_q[15:0];  hi_hw = line_q[31:16]; end
            2'b01: begin lo_hw = line_q[31:16]; hi_hw = line_q[47:32]; end
            2'b10: begin lo_hw = line_q[47:32]; hi_hw = line_q[63:48]; end
            default: begin lo_hw = line_q[63:48]; hi_hw = 16'h0000; end
        endcase

        req_addr = xmode_q ? (pc_q[31:3] + 29'd1) : pc_q[31:3];

        if (xmode_q) begin
            instr_sel = {line_q[15:0], hw_q};
        end else if (lo_hw[1:0] == 2'b11 && pc_q[2:1] != 2'b11) begin
            instr_sel = {hi_hw, lo_hw};
        end else begin
            instr_sel = {16'h0000, lo_hw};
        end

        is16     = (instr_sel[1:0] != 2'b11);
        straddle = (state_q == S_RUN) && !xmode_q &&
                   (pc_q[2:1] == 2'b11) && (lo_hw[1:0] == 2'b11);
        valid    = (state_q == S_RUN) && !straddle;
        accept   = valid && !bus.dec_stall && !bus.redirect_valid;
        pc_d     = {pc_q, 1'b0} + (is16 ? 32'd2 : 32'd4);
    end

    // Output decode. The request strobe drops in the same cycle a redirect
    // arrives so a stale line address never reaches the SRAM.
    assign bus.sram_cs     = (state_q == S_REQ) && !bus.redirect_valid;
    assign bus.sram_addr   = req_addr;
    assign bus.instr_valid = valid;
    assign bus.instr_pc    = {pc_q, 1'b0};
    assign bus.instr       = instr_sel;
    assign bus.instr_is16  = is16;

    assign unused_bits = bus.redirect_pc[0] ^ pc_d[0];

    // Sequencer FSM. Redirect overrides everything, including a line that
    // is arriving in S_WAIT: that line belongs to the old stream and is
    // dropped without touching line_q or tag_q. After an accept we stay in
    // S_RUN as long as the next PC is still inside the held line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC[31:1];
            line_q  <= 64'h0;
            tag_q   <= 29'h0;
            hw_q    <= 16'h0;
            xmode_q <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc_q    <= bus.redirect_pc[31:1];
            xmode_q <= 1'b0;
            state_q <= S_REQ;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                end
                S_REQ: begin
                    if (bus.sram_ready) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    line_q  <= bus.sram_rdata;
                    tag_q   <= req_addr;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (straddle) begin
                        hw_q    <= line_q[63:48];
                        xmode_q <= 1'b1;
                        state_q <= S_REQ;
                    end else if (accept) begin
                        pc_q    <= pc_d[31:1];
                        xmode_q <= 1'b0;
                        if (pc_d[31:3] != tag_q) begin
                            state_q <= S_REQ;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb_fetch_seq_ctrl
// -----------------
// Directed bench for fetch_seq_ctrl with RESET_PC = 0x100. A small SRAM
// model returns a line one cycle after each granted request. Inputs are
// driven 2 time units after each rising edge and outputs checked 1 unit
// later, well clear of the next edge.
module tb_fetch_seq_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [63:0] mem [0:255];

    fetch_seq_ctrl_if bus ();

    fetch_seq_ctrl #(.RESET_PC(32'h0000_0100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: data for a granted request appears the following cycle.
    always @(posedge clk) begin
        if (bus.sram_cs && bus.sram_ready) begin
            bus.sram_rdata <= mem[bus.sram_addr[7:0]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] rpc,
                                 input logic stall, input logic ready);
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.dec_stall      = stall;
        bus.sram_ready     = ready;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Checks the visible instruction-side state in one call.
    task automatic checkInstr(input string tag, input logic v, input logic [31:0] pc,
                              input logic [31:0] ins, input logic is16);
        checkOutput({tag, ".valid"}, {31'h0, bus.instr_valid}, {31'h0, v});
        checkOutput({tag, ".pc"},    bus.instr_pc, pc);
        checkOutput({tag, ".instr"}, bus.instr, ins);
        checkOutput({tag, ".is16"},  {31'h0, bus.instr_is16}, {31'h0, is16});
    endtask

    task automatic checkReq(input string tag, input logic cs, input logic [28:0] addr);
        checkOutput({tag, ".cs"}, {31'h0, bus.sram_cs}, {31'h0, cs});
        if (cs) begin
            checkOutput({tag, ".addr"}, {3'b0, bus.sram_addr}, {3'b0, addr});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 64'h0;
        mem[8'h20] = 64'h0000_0013_0000_0093;
        mem[8'h00] = 64'h4501_00A5_0513_4581;
        mem[8'h01] = 64'h0001_0001_4581_00A5;
        mem[8'h60] = 64'hDEAD_BEEF_DEAD_BEEF;
        mem[8'h40] = 64'h1111_2222_4501_3333;
        bus.sram_rdata = 64'h0;

        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        tick();
        checkReq("reset", 1'b0, 29'h0);
        checkInstr("reset", 1'b0, 32'h100, 32'h0, 1'b1);

        // Reset release: IDLE -> REQ -> WAIT -> RUN.
        rst = 1'b0;
        tick();
        checkReq("req0", 1'b1, 29'h20);
        checkOutput("req0.valid", {31'h0, bus.instr_valid}, 32'h0);
        tick();
        checkReq("wait0", 1'b0, 29'h0);
        checkOutput("wait0.valid", {31'h0, bus.instr_valid}, 32'h0);
        tick();
        checkInstr("run100", 1'b1, 32'h100, 32'h0000_0093, 1'b0);
        tick();
        checkInstr("run104", 1'b1, 32'h104, 32'h0000_0013, 1'b0);
        tick();
        checkReq("req108", 1'b1, 29'h21);
        checkOutput("req108.valid", {31'h0, bus.instr_valid}, 32'h0);

        // Redirect to the mixed line at PC 0.
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b1);
        checkReq("redirReq", 1'b0, 29'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkReq("reqMix", 1'b1, 29'h0);
        tick();
        tick();
        checkInstr("mix0", 1'b1, 32'h0, 32'h0000_4581, 1'b1);
        tick();
        checkInstr("mix2", 1'b1, 32'h2, 32'h00A5_0513, 1'b0);
        tick();
        checkInstr("mix6", 1'b1, 32'h6, 32'h0000_4501, 1'b1);
        tick();
        checkReq("mixRefetch", 1'b1, 29'h1);
        checkOutput("mixRefetch.valid", {31'h0, bus.instr_valid}, 32'h0);

        // Straddle: line0 ends with 0x0513, line1 starts with 0x00A5.
        mem[8'h00] = 64'h0513_0001_0001_0001;
        applyStimulus(1'b1, 32'h6, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkReq("strReq0", 1'b1, 29'h0);
        tick();
        tick();
        checkOutput("strDetect.valid", {31'h0, bus.instr_valid}, 32'h0);
        checkReq("strDetect", 1'b0, 29'h0);
        tick();
        checkOutput("strReq1.valid", {31'h0, bus.instr_valid}, 32'h0);
        checkReq("strReq1", 1'b1, 29'h1);
        tick();
        checkOutput("strWait.valid", {31'h0, bus.instr_valid}, 32'h0);
        tick();
        checkInstr("str6", 1'b1, 32'h6, 32'h00A5_0513, 1'b0);
        tick();
        checkInstr("strA", 1'b1, 32'hA, 32'h0000_4581, 1'b1);
        checkReq("strA", 1'b0, 29'h0);

        // Decoder stall for 5 cycles holds everything.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkInstr("stall", 1'b1, 32'hA, 32'h0000_4581, 1'b1);
            checkReq("stall", 1'b0, 29'h0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        checkInstr("postStall", 1'b1, 32'hC, 32'h0000_0001, 1'b1);

        // Redirect away, then redirect again while the line is in flight.
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b1);
        checkOutput("redirNoAccept.valid", {31'h0, bus.instr_valid}, 32'h1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkReq("req300", 1'b1, 29'h60);
        tick();
        applyStimulus(1'b1, 32'h203, 1'b0, 1'b1);
        checkOutput("wait300.valid", {31'h0, bus.instr_valid}, 32'h0);

        // SRAM port withheld for 4 cycles in S_REQ.
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkReq("noGrant", 1'b1, 29'h40);
            checkOutput("noGrant.valid", {31'h0, bus.instr_valid}, 32'h0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkReq("grant", 1'b1, 29'h40);
        tick();
        checkReq("wait202", 1'b0, 29'h0);
        checkOutput("wait202.valid", {31'h0, bus.instr_valid}, 32'h0);
        tick();
        checkInstr("run202", 1'b1, 32'h202, 32'h0000_4501, 1'b1);

        // Asynchronous reset mid-run.
        rst = 1'b1;
        #1;
        checkInstr("midReset", 1'b0, 32'h100, 32'h0, 1'b1);
        checkReq("midReset", 1'b0, 29'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
